// File: rtl/ram_hs_if.sv
// Request/response bundle for ram_hs. The master drives the request fields,
// the slave (the memory) returns ready, read data and clear status.
interface ram_hs_if #(
   parameter int DW = 16,
   parameter int AW = 6
);
   // A request is taken on a rising edge where req=1 and ready=1; a request
   // presented while ready=0 is dropped, not queued. rvalid is a one-cycle
   // pulse per accepted read, in order; rdata holds until the next read returns.
   logic            req;
   logic            we;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] be;
   logic            ready;
   logic            rvalid;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic [0:0]      state;

   modport master (
      output req, we, addr, wdata, be,
      input  ready, rvalid, rdata, busy, state
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output ready, rvalid, rdata, busy, state
   );
endinterface

// File: rtl/ram_hs.sv
// Single-port word RAM with byte-lane writes and a 1- or 2-cycle read pipeline.
// Define RAM_HS_CLEAR_EN to zero the whole array after every reset.
module ram_hs #(
   parameter int DW       = 16,
   parameter int AW       = 6,
   parameter int READ_LAT = 1
) (
   input  logic     clk,
   input  logic     rst,
   ram_hs_if.slave  bus
);
   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [DW-1:0]       mem [DEPTH];
   logic                ready_int;
   logic                clr_wr;
   logic [AW-1:0]       clr_addr;
   logic                wr_acc;
   logic                rd_acc;
   logic [READ_LAT-1:0] vpipe;
   logic [DW-1:0]       rdata_q;

`ifdef RAM_HS_CLEAR_EN
   logic [0:0]    state_q;
   logic [AW-1:0] clr_cnt;

   // One word cleared per cycle; the counter wraps to 0 as the FSM leaves CLEAR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         clr_cnt <= '0;
      end else if (state_q == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == {AW{1'b1}}) begin
            state_q <= ST_IDLE;
         end
      end
   end

   assign ready_int = (state_q == ST_IDLE);
   assign clr_wr    = (state_q == ST_CLEAR);
   assign clr_addr  = clr_cnt;
   assign bus.busy  = (state_q == ST_CLEAR);
   assign bus.state = state_q;
`else
   assign ready_int = 1'b1;
   assign clr_wr    = 1'b0;
   assign clr_addr  = '0;
   assign bus.busy  = 1'b0;
   assign bus.state = ST_IDLE;
`endif

   assign bus.ready = ready_int;
   assign wr_acc    = bus.req && ready_int && bus.we;
   assign rd_acc    = bus.req && ready_int && !bus.we;

   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.be[i]) begin
               mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
         end
      end
   end

   // The word is captured on the accept edge, so a write accepted later
   // never disturbs a read already in flight.
   generate
      if (READ_LAT == 1) begin : g_lat1
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vpipe   <= '0;
               rdata_q <= '0;
            end else begin
               vpipe[0] <= rd_acc;
               if (rd_acc) begin
                  rdata_q <= mem[bus.addr];
               end
            end
         end
      end else begin : g_lat2
         logic [DW-1:0] stage_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vpipe   <= '0;
               stage_q <= '0;
               rdata_q <= '0;
            end else begin
               vpipe <= {vpipe[0], rd_acc};
               if (rd_acc) begin
                  stage_q <= mem[bus.addr];
               end
               if (vpipe[0]) begin
                  rdata_q <= stage_q;
               end
            end
         end
      end
   endgenerate

   assign bus.rvalid = vpipe[READ_LAT-1];
   assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_ram_hs.sv
// Scoreboard bench for ram_hs: one READ_LAT=1 and one READ_LAT=2 instance
// driven in lockstep; define RAM_HS_CLEAR_EN to exercise the clear sequence.
module tb_ram_hs;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   pcnt = 0;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] exp_q1[$];
   logic [15:0] exp_q2[$];
   int          exp_t1[$];
   int          exp_t2[$];
   logic [15:0] e1, e2;
   int          t1, t2;
   int          n;

   ram_hs_if #(.DW(16), .AW(6)) bus1 ();
   ram_hs_if #(.DW(16), .AW(6)) bus2 ();

   ram_hs #(.DW(16), .AW(6), .READ_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   ram_hs #(.DW(16), .AW(6), .READ_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) pcnt <= pcnt + 1;

   initial begin
      #300000;
      $display("FAIL timeout actual=still running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req_v);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic op(input bit w, input logic [5:0] a, input logic [15:0] d, input logic [1:0] b,
                     input logic [15:0] e, input bit m1, input bit m2, input bit track);
      @(negedge clk);
      bus1.req = m1; bus1.we = w; bus1.addr = a; bus1.wdata = d; bus1.be = b;
      bus2.req = m2; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.be = b;
      if (!w && track) begin
         if (m1) begin exp_q1.push_back(e); exp_t1.push_back(pcnt + 1); end
         if (m2) begin exp_q2.push_back(e); exp_t2.push_back(pcnt + 2); end
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
      op(1'b1, a, d, b, 16'h0, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] e);
      op(1'b0, a, 16'h0, 2'b00, e, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         bus1.req = 1'b0;
         bus2.req = 1'b0;
      end
   endtask

   // Counts cycles from rst deassert until busy drops, optionally hammering
   // requests that must all be ignored.
   task automatic wait_clear(input bit drive, output int cnt);
      cnt = 0;
      while (bus1.busy === 1'b1 && cnt < 200) begin
         check("ready_low_in_clear", bus1.ready, 1'b0);
         check("busy2_in_clear", bus2.busy, 1'b1);
         if (drive) begin
            bus1.req = 1'b1; bus1.we = cnt[0]; bus1.addr = 6'd3; bus1.wdata = 16'hFFFF; bus1.be = 2'b11;
            bus2.req = 1'b1; bus2.we = cnt[0]; bus2.addr = 6'd3; bus2.wdata = 16'hFFFF; bus2.be = 2'b11;
         end
         @(negedge clk);
         cnt++;
      end
      bus1.req = 1'b0;
      bus2.req = 1'b0;
      check("ready_after_clear", bus1.ready, 1'b1);
      check("busy2_after_clear", bus2.busy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus1.req = 1'b0;
      bus2.req = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rvalid1", bus1.rvalid, 1'b0);
      check("rst_rvalid2", bus2.rvalid, 1'b0);
      check("rst_rdata1", bus1.rdata, 16'h0);
      check("rst_rdata2", bus2.rdata, 16'h0);
`ifdef RAM_HS_CLEAR_EN
      check("rst_ready", bus1.ready, 1'b0);
      check("rst_busy", bus1.busy, 1'b1);
`else
      check("rst_ready", bus1.ready, 1'b1);
      check("rst_busy", bus1.busy, 1'b0);
`endif
      rst = 1'b0;
`ifdef RAM_HS_CLEAR_EN
      wait_clear(1'b0, n);
      check("clear_cycles", n, 64);
`endif
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (bus1.rvalid === 1'b1) begin
         if (exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL lat1_spurious_rvalid actual=rdata %h required=no rvalid", bus1.rdata);
         end else begin
            e1 = exp_q1.pop_front();
            t1 = exp_t1.pop_front();
            check("lat1_rdata", bus1.rdata, e1);
            check("lat1_cycle", pcnt, t1);
         end
      end
      if (bus2.rvalid === 1'b1) begin
         if (exp_q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL lat2_spurious_rvalid actual=rdata %h required=no rvalid", bus2.rdata);
         end else begin
            e2 = exp_q2.pop_front();
            t2 = exp_t2.pop_front();
            check("lat2_rdata", bus2.rdata, e2);
            check("lat2_cycle", pcnt, t2);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0; bus1.be = '0;
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.be = '0;
      do_reset();

      wr(6'd5, 16'hBEEF, 2'b11); rd(6'd5, 16'hBEEF);
      wr(6'd9, 16'h1234, 2'b11); wr(6'd9, 16'hAB00, 2'b10); rd(6'd9, 16'hAB34);
      wr(6'd1, 16'h0011, 2'b11); wr(6'd2, 16'h0022, 2'b11); wr(6'd3, 16'h0033, 2'b11);
      rd(6'd1, 16'h0011); rd(6'd2, 16'h0022); rd(6'd3, 16'h0033);
      wr(6'd10, 16'hA5A5, 2'b11); rd(6'd10, 16'hA5A5);
      wr(6'd10, 16'h00FF, 2'b01); rd(6'd10, 16'hA5FF);
      wr(6'd10, 16'hFFFF, 2'b00); rd(6'd10, 16'hA5FF);
      wr(6'd63, 16'hFFFF, 2'b11); wr(6'd0, 16'h0101, 2'b11);
      rd(6'd63, 16'hFFFF); rd(6'd0, 16'h0101);
      idle(4);

      // a write must leave rdata at the last read value
      wr(6'd0, 16'h2222, 2'b11);
      idle(3);
      check("hold_rdata1", bus1.rdata, 16'h0101);
      check("hold_rdata2", bus2.rdata, 16'h0101);
      rd(6'd0, 16'h2222);
      idle(3);

      // read in flight on the 2-cycle instance, then reset before it returns
      op(1'b0, 6'd5, 16'h0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      bus1.req = 1'b0;
      bus2.req = 1'b0;
      #1;
      check("abort_rvalid2", bus2.rvalid, 1'b0);
      check("abort_rdata2", bus2.rdata, 16'h0);
      check("abort_rdata1", bus1.rdata, 16'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
`ifdef RAM_HS_CLEAR_EN
      wait_clear(1'b0, n);
      check("clear_cycles_2", n, 64);
      rd(6'd5, 16'h0000); rd(6'd0, 16'h0000); rd(6'd63, 16'h0000);
`else
      rd(6'd5, 16'hBEEF); rd(6'd0, 16'h2222); rd(6'd63, 16'hFFFF);
`endif
      idle(4);

`ifdef RAM_HS_CLEAR_EN
      wr(6'd3, 16'h5555, 2'b11); wr(6'd40, 16'h7777, 2'b11);
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("busy_at_addr20", bus1.busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_clear(1'b1, n);
      check("restart_clear_cycles", n, 64);
      rd(6'd3, 16'h0000); rd(6'd40, 16'h0000); rd(6'd20, 16'h0000);
      idle(4);
`endif

      n = 0;
      while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_q1", exp_q1.size(), 0);
      check("drain_q2", exp_q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
